// File: rtl/ordered_dither_pkg.sv
// Shared types, Bayer matrices and helper functions for the ordered-dither pixel stream.
package ordered_dither_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        TRUNC  = 2'd1,
        DITHER = 2'd2
    } mode_e;

    localparam logic [3:0] BAYER2 [2][2] = '{
        '{4'd0, 4'd2},
        '{4'd3, 4'd1}
    };

    localparam logic [3:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6},
        '{4'd3,  4'd11, 4'd1,  4'd9},
        '{4'd15, 4'd7,  4'd13, 4'd5}
    };

    // Reserved encoding falls back to bypass.
    function automatic mode_e decode_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'd1:    r = TRUNC;
            2'd2:    r = DITHER;
            default: r = BYPASS;
        endcase
        return r;
    endfunction

    // Align a k-bit Bayer threshold to the d discarded bits.
    function automatic logic [31:0] scale_thresh(input logic [3:0] t, input int unsigned d,
                                                 input int unsigned k);
        logic [31:0] r;
        if (d >= k) r = 32'(t) << (d - k);
        else        r = 32'(t) >> (k - d);
        return r;
    endfunction

    // Repeat a q_w-bit value MSB-first to fill o_w bits.
    function automatic logic [31:0] rep_bits(input logic [31:0] q, input int unsigned q_w,
                                             input int unsigned o_w);
        logic [31:0] r;
        int unsigned src;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < o_w) begin
                src = q_w - 1 - ((o_w - 1 - i) % q_w);
                r[5'(i)] = q[5'(src)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ordered_dither_stream_quant.sv
// Single-channel quantiser: bypass, truncate or threshold dither, then bit-replicate back to IN_W.
module dither_quant
    import ordered_dither_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 4
) (
    input  logic [IN_W-1:0]       i_c,
    input  mode_e                 i_mode,
    input  logic [IN_W-OUT_W-1:0] i_ts,
    output logic [IN_W-1:0]       o_data_c
);

    localparam int unsigned D = IN_W - OUT_W;

    logic [OUT_W-1:0] w_hi;
    logic [OUT_W-1:0] w_q;
    logic [D-1:0]     w_lo;
    logic             w_up;

    assign w_hi = i_c[IN_W-1:D];
    assign w_lo = i_c[D-1:0];

    // Round up only when the residue beats the threshold and the code is not saturated.
    always_comb begin
        w_up     = (i_mode == DITHER) && (w_lo > i_ts) && (w_hi != '1);
        w_q      = w_up ? (w_hi + OUT_W'(1)) : w_hi;
        o_data_c = (i_mode == BYPASS) ? i_c : IN_W'(rep_bits(32'(w_q), OUT_W, IN_W));
    end

endmodule

// File: rtl/ordered_dither_stream.sv
// Streaming ordered-dither stage: position tracking, per-frame mode latch, 2-deep valid/ready pipe.
module ordered_dither_stream
    import ordered_dither_pkg::*;
#(
    parameter int unsigned IN_W     = 8,
    parameter int unsigned OUT_W    = 4,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned BAYER_N  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_sof,
    input  logic                     s_eol,
    input  logic [CHANNELS*IN_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic [CHANNELS*IN_W-1:0] m_data
);

    localparam int unsigned PW = (BAYER_N == 2) ? 1 : 2;
    localparam int unsigned K  = 2 * PW;
    localparam int unsigned D  = IN_W - OUT_W;
    localparam int unsigned DW = CHANNELS * IN_W;

    logic [PW-1:0] r_x, r_y;
    logic [PW-1:0] w_x, w_y;
    mode_e         r_mode, w_mode;

    logic          r_s1_valid, r_s1_sof, r_s1_eol;
    logic [DW-1:0] r_s1_data;
    mode_e         r_s1_mode;
    logic [D-1:0]  r_s1_ts;

    logic          r_s2_valid, r_s2_sof, r_s2_eol;
    logic [DW-1:0] r_s2_data;

    logic          w_s1_ld, w_s2_ld, w_s_fire;
    logic [3:0]    w_t;
    logic [D-1:0]  w_ts;
    logic [DW-1:0] w_q;

    // Each stage loads when empty or when its contents move on.
    assign w_s2_ld  = !r_s2_valid || m_ready;
    assign w_s1_ld  = !r_s1_valid || w_s2_ld;
    assign s_ready  = w_s1_ld;
    assign w_s_fire = s_valid && w_s1_ld;

    // A sof beat sits at the origin and uses the mode presented with it.
    assign w_x    = s_sof ? '0 : r_x;
    assign w_y    = s_sof ? '0 : r_y;
    assign w_mode = s_sof ? decode_mode(mode) : r_mode;

    generate
        if (BAYER_N == 2) begin : g_bayer2
            assign w_t = BAYER2[w_y][w_x];
        end else begin : g_bayer4
            assign w_t = BAYER4[w_y][w_x];
        end
    endgenerate

    assign w_ts = D'(scale_thresh(w_t, D, K));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_mode <= BYPASS;
        end else if (w_s_fire) begin
            if (s_eol) begin
                r_x <= '0;
                r_y <= w_y + PW'(1);
            end else begin
                r_x <= w_x + PW'(1);
                r_y <= w_y;
            end
            if (s_sof) r_mode <= w_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= BYPASS;
            r_s1_ts    <= '0;
        end else if (w_s1_ld) begin
            r_s1_valid <= s_valid;
            if (s_valid) begin
                r_s1_sof  <= s_sof;
                r_s1_eol  <= s_eol;
                r_s1_data <= s_data;
                r_s1_mode <= w_mode;
                r_s1_ts   <= w_ts;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        dither_quant #(
            .IN_W (IN_W),
            .OUT_W(OUT_W)
        ) u_quant (
            .i_c     (r_s1_data[g*IN_W +: IN_W]),
            .i_mode  (r_s1_mode),
            .i_ts    (r_s1_ts),
            .o_data_c(w_q[g*IN_W +: IN_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_eol   <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s2_ld) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sof  <= r_s1_sof;
                r_s2_eol  <= r_s1_eol;
                r_s2_data <= w_q;
            end
        end
    end

    assign m_valid = r_s2_valid;
    assign m_sof   = r_s2_sof;
    assign m_eol   = r_s2_eol;
    assign m_data  = r_s2_data;

endmodule

// File: tb/tb_ordered_dither_stream.sv
// Scoreboard bench for ordered_dither_stream: directed cases plus randomized traffic and backpressure.
module tb_ordered_dither_stream;

    localparam int unsigned IN_W     = 8;
    localparam int unsigned OUT_W    = 4;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned BAYER_N  = 4;
    localparam int unsigned DW       = CHANNELS * IN_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          s_valid, s_ready, s_sof, s_eol;
    logic [DW-1:0] s_data;
    logic          m_valid, m_sof, m_eol;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;

    logic rdy_force = 1'b1;
    logic rdy_rand  = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW+1:0] exp_q[$];
    int mdl_mode = 0;
    int mdl_x    = 0;
    int mdl_y    = 0;

    logic          hold_chk = 1'b0;
    logic [DW+1:0] hold_val;

    ordered_dither_stream #(
        .IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CHANNELS), .BAYER_N(BAYER_N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_eol(s_eol), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .m_data(m_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        m_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bayer matrix built by the recursive doubling rule, not a lookup table.
    function automatic int bayer_val(input int n, input int x, input int y);
        int h, sub, off;
        if (n == 1) return 0;
        h   = n / 2;
        sub = bayer_val(h, x % h, y % h);
        case ({y >= h, x >= h})
            2'b00:   off = 0;
            2'b01:   off = 2;
            2'b10:   off = 3;
            default: off = 1;
        endcase
        return 4 * sub + off;
    endfunction

    function automatic logic [IN_W-1:0] ref_chan(input int md, input int c, input int x, input int y);
        int d, k, t, ts, hi, lo, q, bits;
        longint acc;
        d = IN_W - OUT_W;
        k = 2 * $clog2(BAYER_N);
        if (md != 1 && md != 2) return IN_W'(c);
        t  = bayer_val(BAYER_N, x % BAYER_N, y % BAYER_N);
        ts = (d >= k) ? t * (1 << (d - k)) : t / (1 << (k - d));
        hi = c / (1 << d);
        lo = c % (1 << d);
        q  = hi;
        if (md == 2 && lo > ts && hi < (1 << OUT_W) - 1) q = hi + 1;
        acc  = 0;
        bits = 0;
        while (bits < IN_W) begin
            acc  = acc * (64'd1 << OUT_W) + q;
            bits += OUT_W;
        end
        return IN_W'(acc >> (bits - IN_W));
    endfunction

    task automatic model_accept(input logic [1:0] md, input logic sof, input logic eol,
                                input logic [DW-1:0] d);
        logic [DW-1:0] e;
        if (sof) begin
            mdl_mode = (md == 2'd3) ? 0 : int'(md);
            mdl_x    = 0;
            mdl_y    = 0;
        end
        for (int c = 0; c < CHANNELS; c++)
            e[c*IN_W +: IN_W] = ref_chan(mdl_mode, int'(d[c*IN_W +: IN_W]), mdl_x, mdl_y);
        exp_q.push_back({sof, eol, e});
        if (eol) begin
            mdl_x = 0;
            mdl_y++;
        end else begin
            mdl_x++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_mode = 0;
        mdl_x    = 0;
        mdl_y    = 0;
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send(input logic [1:0] md, input logic sof, input logic eol, input logic [DW-1:0] d);
        int   guard;
        logic acc;
        guard   = 0;
        mode    = md;
        s_sof   = sof;
        s_eol   = eol;
        s_data  = d;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            if (acc) break;
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        if (acc) model_accept(md, sof, eol, d);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_payload", 64'({m_sof, m_eol, m_data}), 64'(hold_val));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'({m_sof, m_eol, m_data}), 64'd0);
                    chk("queue_nonempty", 64'd0, 64'd1);
                end else begin
                    logic [DW+1:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", 64'(m_data), 64'(e[DW-1:0]));
                    chk("out_sof", 64'(m_sof), 64'(e[DW+1]));
                    chk("out_eol", 64'(m_eol), 64'(e[DW]));
                end
            end
            hold_chk = m_valid && !m_ready;
            hold_val = {m_sof, m_eol, m_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        s_data  = '0;
        mode    = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_sof_eol", 64'({m_sof, m_eol}), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;

        // Bypass with exact two-cycle latency
        send(2'd0, 1'b1, 1'b0, 24'hA73CFF);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_m_valid", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_m_valid", 64'(m_valid), 64'd1);
        chk("lat_cycle2_m_sof", 64'(m_sof), 64'd1);
        idle(2);

        // Truncate, dither by position, saturation
        send(2'd1, 1'b1, 1'b1, {3{8'hA7}});
        send(2'd2, 1'b1, 1'b0, {3{8'hA7}});
        send(2'd2, 1'b0, 1'b1, {3{8'hA7}});
        send(2'd2, 1'b0, 1'b0, {3{8'hA7}});
        send(2'd2, 1'b1, 1'b1, {3{8'hFF}});
        send(2'd2, 1'b1, 1'b0, {3{8'hF1}});
        idle(4);

        // Mode changes only take effect at sof; reserved mode behaves as bypass
        send(2'd1, 1'b1, 1'b0, {3{8'hA7}});
        send(2'd2, 1'b0, 1'b0, {3{8'hA7}});
        send(2'd0, 1'b0, 1'b0, {3{8'h5A}});
        send(2'd3, 1'b1, 1'b0, {3{8'h5A}});
        send(2'd2, 1'b0, 1'b0, {3{8'h5A}});
        idle(4);

        // Backpressure burst
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(2'd2, i == 0, i == 2, DW'($urandom));
                idle(1);
            end
            begin
                rdy_force = 1'b1;
                repeat (2) @(posedge clk);
                #1 rdy_force = 1'b0;
                repeat (3) @(negedge clk);
                chk("bp_s_ready_low", 64'(s_ready), 64'd0);
                chk("bp_m_valid_held", 64'(m_valid), 64'd1);
                repeat (2) @(posedge clk);
                #1 rdy_force = 1'b1;
            end
        join
        idle(6);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-frame with beats in flight
        rdy_force = 1'b0;
        idle(1);
        send(2'd2, 1'b1, 1'b0, DW'($urandom));
        send(2'd2, 1'b0, 1'b0, DW'($urandom));
        s_valid = 1'b0;
        s_sof   = 1'b0;
        @(negedge clk);
        chk("pre_rst_m_valid", 64'(m_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_m_data", 64'(m_data), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_force = 1'b1;
        @(negedge clk);
        chk("postrst_s_ready", 64'(s_ready), 64'd1);
        chk("postrst_m_valid", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;
        // Without a sof the latched mode is still bypass after reset
        send(2'd2, 1'b0, 1'b0, {3{8'hA7}});
        send(2'd2, 1'b0, 1'b1, {3{8'hC3}});
        idle(4);

        // Randomized traffic with random downstream stalls
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 DW'($urandom));
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("final_drain", 64'(exp_q.size()), 64'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
